reg_access_master: RTL and testbench
====================================

// Module: reg_access_master
// PURPOSE
//  Initiator end of the Master-FPGA register link: turns one read/write request into the bus sequence
//  the channel register block expects: select (reg_num_le), then wr_en or rd_en.
//  It captures readback data and returns one response per request.
//  Sits in the Master-side interconnect between the command decoder and each channel FPGA link.
// PARAMETERS
//  RD_LATENCY     1  cycles from rd_en-high cycle until link_rx_data holds the register value (1..15)
//  SKIP_RESELECT  1  1 = omit SEL/CHK when req_reg_num equals the cached selection
// PORTS
//  clk              in   1   125 MHz interconnect clock
//  reset            in   1   synchronous, active-high
//  req_valid        in   1   request present
//  req_ready        out  1   request accepted when req_valid & req_ready
//  req_write        in   1   1 = write, 0 = read
//  req_reg_num      in   32  register number; upper 28 bits must be 0 for a legal access
//  req_wdata        in   32  write data
//  rsp_valid        out  1   response held until rsp_ready
//  rsp_ready        in   1   response consumer ready
//  rsp_rdata        out  32  read data; 0 for writes, unless the verify feature is enabled
//  rsp_err          out  2   00 ok, 01 illegal register, 10 verify mismatch
//  link_tx_data     out  32  to responder rx_data
//  link_rx_data     in   32  from responder tx_data
//  link_reg_num_le  out  1   latch link_tx_data as register number
//  link_wr_en       out  1   write link_tx_data to the selected register
//  link_rd_en       out  1   load readback register
//  link_illegal     in   1   responder illegal_reg_num flag
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values:
//    - req_ready = 0 during reset, then 1 in IDLE.
//    - All other outputs = 0.
//    - sel_valid = 0, state = IDLE.
//  - FSM states and transitions:
//    - IDLE:
//      - req_ready = 1.
//      - On accept, latch write, reg_num and wdata; deassert req_ready.
//      - Go to WR or RD if SKIP_RESELECT and sel_valid and reg_num == sel_cache; otherwise go to SEL.
//    - SEL (1 cycle): link_tx_data = reg_num, link_reg_num_le = 1.
//      - Then sel_cache <= reg_num, sel_valid <= 1. Go to CHK.
//    - CHK (1 cycle): sample link_illegal.
//      - If set: rsp_err = 01, go to RSP. No wr_en or rd_en is issued.
//      - Otherwise go to WR or RD.
//    - WR (1 cycle): link_tx_data = wdata, link_wr_en = 1. Go to RSP (or VRD if MASTER_VERIFY_EN).
//    - RD (1 cycle): link_rd_en = 1. Load wait counter with RD_LATENCY-1, go to RDW.
//    - RDW: decrement the counter.
//      - At 0, capture link_rx_data into rsp_rdata on that cycle, go to RSP.
//    - RSP: rsp_valid = 1 until rsp_ready. Then clear rsp_err, go to IDLE.
//      - rsp_valid and rsp_ready high in the same cycle: response retires and IDLE is entered next cycle.
//  - Latency, request accept to rsp_valid rising:
//    - Cached write: 2 cycles. Uncached write: 4 cycles.
//    - Cached read: 2 + RD_LATENCY cycles. Uncached read: 4 + RD_LATENCY cycles.
//  - Illegal register: sel_cache is still updated, because the responder latched it.
//    - A repeat illegal number therefore re-runs SEL/CHK (a cache hit requires the illegal flag to have been clear).
//    - Cache hit condition: sel_valid & sel_legal.
//  - Strobes are mutually exclusive and each is high for exactly one cycle per state visit.
//  - link_tx_data holds its last value when no strobe is active.
//  - reset mid-operation:
//    - Return to IDLE next cycle; all strobes drop.
//    - sel_valid clears (responder reg_num also resets to 0).
//    - The pending response is discarded.
//  - req_valid while busy is ignored (req_ready = 0); no queueing.
// CONFIGURATION
//  - MASTER_VERIFY_EN defined: after WR, go to VRD (link_rd_en = 1), then to RDW.
//    - At capture, compare link_rx_data with wdata; on mismatch rsp_err = 10.
//    - rsp_rdata = readback value.
//    - Write latency grows by 1 + RD_LATENCY.
//  - MASTER_VERIFY_EN undefined: VRD and the compare logic are absent; write rsp_rdata = 0.
// STRUCTURE
//  - Shared package reg_link_pkg:
//    - state enum.
//    - RSP_OK = 2'b00, RSP_ILLEGAL = 2'b01, RSP_VERIFY = 2'b10.
//    - REG_NUM_BITS = 4.
//  - Single module; no sub-module. The wait counter is an inline 4-bit down-counter.
// TESTING
//  - Reset then write R2 = 0x00000FFF (uncached):
//    - reg_num_le at accept+1 with tx 0x2; wr_en at accept+3 with tx 0xFFF.
//    - rsp_valid at accept+4, rsp_err 00.
//  - Read R2 immediately (cached, RD_LATENCY = 1):
//    - No reg_num_le; rd_en at accept+1.
//    - rsp_rdata 0x00000FFF, rsp_valid at accept+3.
//  - Write reg_num 0x00000010, responder flags illegal:
//    - SEL and CHK are issued, no wr_en.
//    - rsp_err 01. The next request to 0x10 reselects.
//  - Read R1 with RD_LATENCY = 3 and a responder model returning 0x12345678:
//    - rsp_rdata 0x12345678, rsp_valid at accept+5.
//  - Hold rsp_ready low 10 cycles, then pulse it:
//    - rsp_valid stays high and stable; req_ready = 0 throughout; IDLE follows.
//  - Assert reset during RDW:
//    - Next cycle all link strobes = 0, rsp_valid = 0.
//    - The following request to the same reg performs SEL.
//    - With MASTER_VERIFY_EN, a write to read-only R1 returns rsp_err 10.

Source files
------------

// File: rtl/reg_link_pkg.sv
// Shared types and constants for the Master-FPGA register link.
package reg_link_pkg;

   localparam int         REG_NUM_BITS = 4;

   localparam logic [1:0] RSP_OK       = 2'b00;
   localparam logic [1:0] RSP_ILLEGAL  = 2'b01;
   localparam logic [1:0] RSP_VERIFY   = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEL,
      ST_CHK,
      ST_WR,
      ST_RD,
      ST_VRD,
      ST_RDW,
      ST_RSP
   } state_t;

endpackage

// File: rtl/reg_access_master.sv
// Register-link initiator: one request -> select/check -> strobe -> one held response; busy means req_ready=0.
// Latency 2/4 cycles (cached/uncached write), +RD_LATENCY for reads. MASTER_VERIFY_EN adds write read-back compare.
module reg_access_master
   import reg_link_pkg::*;
#(
   parameter int RD_LATENCY    = 1,
   parameter bit SKIP_RESELECT = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_reg_num,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_err,
   output logic [31:0] link_tx_data,
   input  logic [31:0] link_rx_data,
   output logic        link_reg_num_le,
   output logic        link_wr_en,
   output logic        link_rd_en,
   input  logic        link_illegal
);

   state_t                  state, state_nxt;
   logic                    wr_q;
   logic [31:0]             reg_num_q, wdata_q;
   logic                    sel_valid, sel_legal;
   logic [REG_NUM_BITS-1:0] sel_cache;
   logic [3:0]              cnt;

   logic                    accept, cache_hit, capture, cur_write;
   logic [31:0]             cur_reg, cur_wdata;

   always_comb begin
      accept    = req_valid && req_ready;
      cur_write = accept ? req_write   : wr_q;
      cur_reg   = accept ? req_reg_num : reg_num_q;
      cur_wdata = accept ? req_wdata   : wdata_q;
      // A hit needs a select the responder accepted as legal.
      cache_hit = SKIP_RESELECT && sel_valid && sel_legal &&
                  (req_reg_num[31:REG_NUM_BITS] == '0) &&
                  (req_reg_num[REG_NUM_BITS-1:0] == sel_cache);
      capture   = (state == ST_RDW) && (cnt == 4'd0);

      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = cache_hit ? (cur_write ? ST_WR : ST_RD) : ST_SEL;
         ST_SEL:  state_nxt = ST_CHK;
         ST_CHK:  state_nxt = link_illegal ? ST_RSP : (wr_q ? ST_WR : ST_RD);
`ifdef MASTER_VERIFY_EN
         ST_WR:   state_nxt = ST_VRD;
         ST_VRD:  state_nxt = ST_RDW;
`else
         ST_WR:   state_nxt = ST_RSP;
`endif
         ST_RD:   state_nxt = ST_RDW;
         ST_RDW:  if (capture) state_nxt = ST_RSP;
         ST_RSP:  if (rsp_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= ST_IDLE;
         req_ready       <= 1'b0;
         rsp_valid       <= 1'b0;
         rsp_rdata       <= '0;
         rsp_err         <= RSP_OK;
         link_tx_data    <= '0;
         link_reg_num_le <= 1'b0;
         link_wr_en      <= 1'b0;
         link_rd_en      <= 1'b0;
         wr_q            <= 1'b0;
         reg_num_q       <= '0;
         wdata_q         <= '0;
         sel_valid       <= 1'b0;
         sel_legal       <= 1'b0;
         sel_cache       <= '0;
         cnt             <= '0;
      end else begin
         state           <= state_nxt;
         // Outputs are registered from the next state so they line up with the state they belong to.
         req_ready       <= (state_nxt == ST_IDLE);
         rsp_valid       <= (state_nxt == ST_RSP);
         link_reg_num_le <= (state_nxt == ST_SEL);
         link_wr_en      <= (state_nxt == ST_WR);
         link_rd_en      <= (state_nxt == ST_RD) || (state_nxt == ST_VRD);
         if (state_nxt == ST_SEL)
            link_tx_data <= cur_reg;
         else if (state_nxt == ST_WR)
            link_tx_data <= cur_wdata;

         if (accept) begin
            wr_q      <= req_write;
            reg_num_q <= req_reg_num;
            wdata_q   <= req_wdata;
            rsp_rdata <= '0;
         end

         // The responder latches even an illegal number, so the cache follows it.
         if (state == ST_SEL) begin
            sel_cache <= reg_num_q[REG_NUM_BITS-1:0];
            sel_valid <= 1'b1;
            sel_legal <= 1'b0;
         end
         if (state == ST_CHK) begin
            sel_legal <= !link_illegal;
            if (link_illegal)
               rsp_err <= RSP_ILLEGAL;
         end

         if ((state == ST_RD) || (state == ST_VRD))
            cnt <= 4'(RD_LATENCY - 1);
         else if ((state == ST_RDW) && (cnt != 4'd0))
            cnt <= cnt - 4'd1;

         if (capture) begin
            rsp_rdata <= link_rx_data;
`ifdef MASTER_VERIFY_EN
            if (wr_q && (link_rx_data != wdata_q))
               rsp_err <= RSP_VERIFY;
`endif
         end

         if ((state == ST_RSP) && rsp_ready)
            rsp_err <= RSP_OK;
      end
   end

endmodule

// File: tb/tb_reg_access_master.sv
// Directed bench: two masters (RD_LATENCY 1 and 3), each with a small responder register-file model.
module tb_reg_access_master;

`ifdef MASTER_VERIFY_EN
   localparam int VX = 1;
`else
   localparam int VX = 0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   always #4 clk = ~clk;

   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_write [2];
   logic [31:0] req_reg_num [2];
   logic [31:0] req_wdata [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic [1:0]  rsp_err [2];
   logic [31:0] link_tx_data [2];
   logic [31:0] link_rx_data [2];
   logic        link_reg_num_le [2];
   logic        link_wr_en [2];
   logic        link_rd_en [2];
   logic        link_illegal [2];

   reg_access_master #(.RD_LATENCY(1), .SKIP_RESELECT(1'b1)) u_dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_reg_num(req_reg_num[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
      .link_tx_data(link_tx_data[0]), .link_rx_data(link_rx_data[0]),
      .link_reg_num_le(link_reg_num_le[0]), .link_wr_en(link_wr_en[0]), .link_rd_en(link_rd_en[0]),
      .link_illegal(link_illegal[0])
   );

   reg_access_master #(.RD_LATENCY(3), .SKIP_RESELECT(1'b1)) u_dut1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_reg_num(req_reg_num[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
      .link_tx_data(link_tx_data[1]), .link_rx_data(link_rx_data[1]),
      .link_reg_num_le(link_reg_num_le[1]), .link_wr_en(link_wr_en[1]), .link_rd_en(link_rd_en[1]),
      .link_illegal(link_illegal[1])
   );

   // Responder: R1 is read-only 0x12345678, numbers above 15 are illegal, readback delayed by L.
   for (genvar g = 0; g < 2; g++) begin : g_resp
      localparam int L = (g == 0) ? 1 : 3;
      logic [31:0] rf [16];
      logic [31:0] sel;
      logic [31:0] pipe [3];
      logic        illegal_r;

      always @(posedge clk) begin
         if (reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= 32'd0;
            rf[1]     <= 32'h12345678;
            sel       <= 32'd0;
            illegal_r <= 1'b0;
            for (int i = 0; i < 3; i++) pipe[i] <= 32'd0;
         end else begin
            if (link_reg_num_le[g]) begin
               sel       <= link_tx_data[g];
               illegal_r <= (link_tx_data[g][31:4] != 28'd0);
            end
            if (link_wr_en[g] && (sel[31:4] == 28'd0) && (sel[3:0] != 4'd1))
               rf[sel[3:0]] <= link_tx_data[g];
            pipe[0] <= link_rd_en[g] ? rf[sel[3:0]] : pipe[0];
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
         end
      end

      assign link_rx_data[g] = pipe[L-1];
      assign link_illegal[g] = illegal_r;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int          r_le, r_wr, r_rd, r_rsp;
   logic [31:0] r_le_tx, r_wr_tx, r_rdata;
   logic [1:0]  r_err;

   // Issue one request; cycle numbers are counted from the accept edge (1 = first cycle after accept).
   task automatic do_req(input int d, input logic wr, input logic [31:0] rn,
                         input logic [31:0] wd, input int hold);
      int   k;
      logic ok;
      k = 0;
      while (req_ready[d] !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (req_ready[d] !== 1'b1) check("req_ready_wait", 32'(req_ready[d]), 32'd1);
      req_valid[d]   = 1'b1;
      req_write[d]   = wr;
      req_reg_num[d] = rn;
      req_wdata[d]   = wd;
      rsp_ready[d]   = (hold == 0);
      @(negedge clk);
      req_valid[d] = 1'b0;
      r_le = -1; r_wr = -1; r_rd = -1; r_rsp = -1;
      r_le_tx = '0; r_wr_tx = '0; r_rdata = '0; r_err = '0;
      k = 1;
      while (r_rsp < 0 && k <= 40) begin
         if (link_reg_num_le[d] && r_le < 0) begin r_le = k; r_le_tx = link_tx_data[d]; end
         if (link_wr_en[d] && r_wr < 0) begin r_wr = k; r_wr_tx = link_tx_data[d]; end
         if (link_rd_en[d] && r_rd < 0) r_rd = k;
         if (rsp_valid[d]) begin
            r_rsp = k; r_rdata = rsp_rdata[d]; r_err = rsp_err[d];
         end else begin
            @(negedge clk);
            k++;
         end
      end
      if (r_rsp < 0) check("rsp_timeout", 32'd0, 32'd1);
      if (hold > 0) begin
         ok = 1'b1;
         repeat (hold) begin
            @(negedge clk);
            ok &= rsp_valid[d] && (rsp_rdata[d] == r_rdata) && !req_ready[d];
         end
         check("hold_stable", 32'(ok), 32'd1);
         rsp_ready[d] = 1'b1;
         @(negedge clk);
         check("retire_rsp_valid", 32'(rsp_valid[d]), 32'd0);
         check("retire_req_ready", 32'(req_ready[d]), 32'd1);
      end else begin
         @(negedge clk);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0; req_write[i] = 1'b0; req_reg_num[i] = '0;
         req_wdata[i] = '0; rsp_ready[i] = 1'b1;
      end
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready[0]), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      check("rst_strobes", {29'd0, link_reg_num_le[0], link_wr_en[0], link_rd_en[0]}, 32'd0);
      check("rst_tx_data", link_tx_data[0], 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_ready0", 32'(req_ready[0]), 32'd1);
      check("idle_ready1", 32'(req_ready[1]), 32'd1);

      // Uncached write R2
      do_req(0, 1'b1, 32'h2, 32'h0000_0FFF, 0);
      check("w2_le_cyc", r_le, 1);
      check("w2_le_tx", r_le_tx, 32'h2);
      check("w2_wr_cyc", r_wr, 3);
      check("w2_wr_tx", r_wr_tx, 32'hFFF);
      check("w2_rd_cyc", r_rd, (VX != 0) ? 4 : -1);
      check("w2_rsp_cyc", r_rsp, 4 + VX * 2);
      check("w2_err", 32'(r_err), 32'd0);
      check("w2_rdata", r_rdata, (VX != 0) ? 32'hFFF : 32'h0);

      // Cached read R2
      do_req(0, 1'b0, 32'h2, 32'h0, 0);
      check("r2_le_cyc", r_le, -1);
      check("r2_rd_cyc", r_rd, 1);
      check("r2_rsp_cyc", r_rsp, 3);
      check("r2_rdata", r_rdata, 32'hFFF);
      check("r2_err", 32'(r_err), 32'd0);

      // Illegal register, twice: both must reselect
      for (int n = 0; n < 2; n++) begin
         do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0);
         check("ill_le_cyc", r_le, 1);
         check("ill_le_tx", r_le_tx, 32'h10);
         check("ill_wr_cyc", r_wr, -1);
         check("ill_rd_cyc", r_rd, -1);
         check("ill_rsp_cyc", r_rsp, 3);
         check("ill_err", 32'(r_err), 32'h1);
      end

      // R2 after the illegal select is uncached again
      do_req(0, 1'b0, 32'h2, 32'h0, 0);
      check("r2u_le_cyc", r_le, 1);
      check("r2u_rd_cyc", r_rd, 3);
      check("r2u_rsp_cyc", r_rsp, 5);
      check("r2u_rdata", r_rdata, 32'hFFF);

      // Response backpressure
      do_req(0, 1'b0, 32'h2, 32'h0, 10);
      check("bp_rsp_cyc", r_rsp, 3);
      check("bp_rdata", r_rdata, 32'hFFF);

      // RD_LATENCY = 3: uncached then cached read of R1
      do_req(1, 1'b0, 32'h1, 32'h0, 0);
      check("r1u_le_cyc", r_le, 1);
      check("r1u_rd_cyc", r_rd, 3);
      check("r1u_rsp_cyc", r_rsp, 7);
      check("r1u_rdata", r_rdata, 32'h1234_5678);
      do_req(1, 1'b0, 32'h1, 32'h0, 0);
      check("r1c_le_cyc", r_le, -1);
      check("r1c_rd_cyc", r_rd, 1);
      check("r1c_rsp_cyc", r_rsp, 5);
      check("r1c_rdata", r_rdata, 32'h1234_5678);

      // Reset while waiting in RDW
      req_valid[1] = 1'b1; req_write[1] = 1'b0; req_reg_num[1] = 32'h1;
      @(negedge clk);
      req_valid[1] = 1'b0;
      check("rrst_rd_en", 32'(link_rd_en[1]), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rrst_strobes", {29'd0, link_reg_num_le[1], link_wr_en[1], link_rd_en[1]}, 32'd0);
      check("rrst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
      check("rrst_req_ready", 32'(req_ready[1]), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("rrst_ready_back", 32'(req_ready[1]), 32'd1);
      do_req(1, 1'b0, 32'h1, 32'h0, 0);
      check("rrst_le_cyc", r_le, 1);
      check("rrst_rsp_cyc", r_rsp, 7);
      check("rrst_rdata", r_rdata, 32'h1234_5678);

      // Write to read-only R1
      do_req(0, 1'b1, 32'h1, 32'hAAAA_5555, 0);
      check("w1_le_cyc", r_le, 1);
      check("w1_wr_tx", r_wr_tx, 32'hAAAA_5555);
      check("w1_rsp_cyc", r_rsp, 4 + VX * 2);
      check("w1_err", 32'(r_err), (VX != 0) ? 32'h2 : 32'h0);
      check("w1_rdata", r_rdata, (VX != 0) ? 32'h1234_5678 : 32'h0);
      check("w1_err_cleared", 32'(rsp_err[0]), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
